dmux8_dispatch: RTL and testbench
=================================

# dmux8_dispatch

Round-robin dispatcher that sequences an 8-way demultiplexer. It accepts words from one producer over a valid/ready handshake, holds each word in a one-entry buffer, and steers it to one of eight consumer channels in rotating order. Disabled channels are skipped, and a channel that stalls too long is bypassed. It sits between a single stream source and eight parallel sinks, and drives the demux select and the one-hot valid lines.

## Interface
- DATA_W, default 16: width of the data word.
- MAX_WAIT, default 4: number of consecutive stalled cycles on the target channel before the word is retargeted. 0 disables retargeting.
- clk  input  1  clock; all state is updated on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  dispatcher can accept a word this cycle.
- in_data  input  DATA_W  producer word.
- chan_en  input  8  per-channel enable mask; sampled every cycle.
- out_ready  input  8  per-channel consumer ready.
- out_valid  output  8  one-hot (or zero) valid to the consumers.
- out_data  output  DATA_W  held word, shared by all channels.
- out_sel  output  3  current target channel (the demux select).
- skip_cnt  output  16  saturating count of retargets.

## Operation
- States: IDLE (buffer empty) and HOLD (buffer full). Pointer `ptr[2:0]` names the target channel.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On in_valid: capture in_data, go to HOLD.
- HOLD:
  - out_valid[ptr] = chan_en[ptr]; all other bits are 0.
  - Fire condition: chan_en[ptr] & out_ready[ptr].
  - in_ready = fire, so the buffer is refilled in the same cycle.
- Fire:
  - ptr moves to the next enabled channel strictly after ptr, wrapping 7→0. If ptr is the only enabled channel, it stays.
  - The wait counter clears.
  - If in_valid also holds, the new word is captured and the state stays HOLD. Otherwise the state goes to IDLE.
- chan_en[ptr]=0 in HOLD: ptr advances to the next enabled channel on the next edge. No stall is counted and skip_cnt does not increment.
- chan_en all zero: ptr holds, out_valid=0, and the word stays buffered.
- Stall (chan_en[ptr]=1, out_ready[ptr]=0):
  - The wait counter increments each stalled cycle.
  - When it reaches MAX_WAIT (MAX_WAIT≠0), ptr advances to the next enabled channel, the wait counter clears, and skip_cnt increments (saturates at 16'hFFFF).
  - out_valid on the old channel drops at that edge. This retarget is the only case where valid falls without a transfer.
- The pointer is not changed by the transition into IDLE. The next word goes to the channel after the last one served.
- Reset mid-operation discards the buffered word.

## Timing
- Reset values: state=IDLE, ptr=0, wait counter=0, in_ready=1, out_valid=8'h00, out_data=0, out_sel=0, skip_cnt=0.
- Latency: a word accepted at edge N is visible on out_data/out_valid after edge N. The earliest consumer transfer is at edge N+1.
- Throughput: 1 word/cycle while consecutive targets are ready.
- out_sel = ptr at all times, including in IDLE.
- out_data is stable while in HOLD without a fire.
- Handshake outputs are combinational from state, ptr and chan_en.
- in_ready also depends combinationally on out_ready[ptr] (pass-through). No out_* signal depends on in_valid.
- Next-enabled search: combinational, priority starting from ptr+1 modulo 8.

## Structure
- Package `dmux8_dispatch_pkg`: NCHAN=8, SEL_W=3, the state enum {IDLE, HOLD}, and the skip_cnt width (16).
- Sub-module `rr_next8`:
  - Inputs ptr[2:0] and mask[7:0].
  - Outputs next[2:0] (first set bit after ptr, wrapping) and any (mask≠0).
- The one-hot out_valid is a 3→8 decode of ptr gated by chan_en[ptr]. It stays inline.

## Test plan
- Reset release, all enabled, all ready; stream A0..A9 back-to-back → one word/cycle, channels 0,1,…,7,0,1 in order, in_ready held high.
- chan_en=8'b1010_0101, all ready, 4 words → delivered on channels 0,2,5,7. The next word goes to channel 0. skip_cnt=0.
- MAX_WAIT=4, out_ready[1]=0, word held at ptr=1 → out_valid[1] high for 4 cycles, then out_valid[2] high. skip_cnt=1, and in_ready=0 during the stall.
- chan_en=0 with a word held → out_valid=0 indefinitely. Set chan_en=8'h08 → delivered on channel 3 two edges later (advance, then fire).
- Fire and in_valid in the same cycle with only channel 4 enabled → new word captured, ptr stays 4, no IDLE cycle.
- rst_n pulsed low for less than one clock while in HOLD → immediate return to IDLE, out_valid=0, skip_cnt=0, and the held word is never delivered.

Source files
------------

// File: rtl/dmux8_dispatch_pkg.sv
// dmux8_dispatch_pkg
// Shared constants and types for the 8-way round-robin dispatcher.
//   NCHAN  - number of consumer channels
//   SEL_W  - width of the channel select / pointer
//   SKIP_W - width of the saturating retarget counter
//   state_e - dispatcher buffer state (empty / full)
package dmux8_dispatch_pkg;

    localparam int NCHAN  = 8;
    localparam int SEL_W  = 3;
    localparam int SKIP_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/rr_next8.sv
// rr_next8
// Finds the first set bit of mask strictly after ptr, wrapping 7 -> 0.
// Position ptr itself is examined last, so a lone enabled channel maps to
// itself. With an all-zero mask, next returns ptr unchanged.
//   ptr  [2:0] in  : current pointer
//   mask [7:0] in  : candidate channels
//   next [2:0] out : selected channel
//   any        out : mask has at least one bit set
module rr_next8
    import dmux8_dispatch_pkg::*;
(
    input  logic [SEL_W-1:0] ptr,
    input  logic [NCHAN-1:0] mask,
    output logic [SEL_W-1:0] next,
    output logic             any
);

    logic [SEL_W-1:0] idx;
    logic             found;

    always_comb begin
        next  = ptr;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NCHAN; i++) begin
            // i == NCHAN wraps back onto ptr itself.
            idx = ptr + SEL_W'(i);
            if (!found && mask[idx]) begin
                next  = idx;
                found = 1'b1;
            end
        end
    end

    assign any = |mask;

endmodule

// File: rtl/dmux8_dispatch.sv
// dmux8_dispatch
// Round-robin dispatcher with a one-entry buffer feeding an 8-way demux.
// Words arrive over a valid/ready handshake and are steered to channels in
// rotating order; disabled channels are skipped and a channel stalled for
// MAX_WAIT consecutive cycles is bypassed.
//   clk, rst_n         : clock, async active-low reset
//   in_valid/in_ready  : producer handshake, in_data the offered word
//   chan_en   [7:0]    : per-channel enable mask
//   out_ready [7:0]    : per-channel consumer ready
//   out_valid [7:0]    : one-hot (or zero) valid to consumers
//   out_data           : buffered word, shared by all channels
//   out_sel   [2:0]    : current target channel (demux select)
//   skip_cnt  [15:0]   : saturating count of stall retargets
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | buffer empty, accepting a word, no valid driven
// HOLD  | buffer full, offering word to channel ptr
module dmux8_dispatch
    import dmux8_dispatch_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [NCHAN-1:0]  chan_en,
    input  logic [NCHAN-1:0]  out_ready,
    output logic [NCHAN-1:0]  out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_sel,
    output logic [SKIP_W-1:0] skip_cnt
);

    localparam logic [0:0] S_IDLE = ST_IDLE;
    localparam logic [0:0] S_HOLD = ST_HOLD;

    // Counter only needs to reach MAX_WAIT-1; the retarget fires on that cycle.
    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

    logic [0:0]        state_q, state_d;
    logic [SEL_W-1:0]  ptr_q,   ptr_d;
    logic [WAIT_W-1:0] wait_q,  wait_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [SKIP_W-1:0] skip_q,  skip_d;

    logic [SEL_W-1:0]  ptr_next;
    logic              any_en;
    logic              hold;
    logic              tgt_en;
    logic              fire;

    rr_next8 u_next (
        .ptr  (ptr_q),
        .mask (chan_en),
        .next (ptr_next),
        .any  (any_en)
    );

    assign hold   = (state_q == S_HOLD);
    assign tgt_en = chan_en[ptr_q];
    assign fire   = hold && tgt_en && out_ready[ptr_q];

    assign in_ready  = !hold || fire;
    assign out_valid = (hold && tgt_en) ? (NCHAN'(1) << ptr_q) : '0;
    assign out_data  = data_q;
    assign out_sel   = ptr_q;
    assign skip_cnt  = skip_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wait_d  = wait_q;
        data_d  = data_q;
        skip_d  = skip_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (fire) begin
                    ptr_d  = ptr_next;
                    wait_d = '0;
                    if (in_valid) begin
                        data_d = in_data;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (!tgt_en) begin
                    // Target disabled: move on without counting a stall.
                    // With no channel enabled ptr_next equals ptr_q.
                    if (any_en) begin
                        ptr_d = ptr_next;
                    end
                    wait_d = '0;
                end else if (MAX_WAIT != 0) begin
                    if (wait_q == WAIT_LAST) begin
                        ptr_d  = ptr_next;
                        wait_d = '0;
                        if (skip_q != '1) begin
                            skip_d = skip_q + 1'b1;
                        end
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            wait_q  <= '0;
            data_q  <= '0;
            skip_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wait_q  <= wait_d;
            data_q  <= data_d;
            skip_q  <= skip_d;
        end
    end

endmodule

// File: tb/tb_dmux8_dispatch.sv
// tb_dmux8_dispatch
// Self-checking bench: expected (channel, word) pairs are queued when a word
// is accepted and popped when a consumer transfer is seen.
module tb_dmux8_dispatch;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [7:0]  chan_en;
    logic [7:0]  out_ready;
    logic [7:0]  out_valid;
    logic [15:0] out_data;
    logic [2:0]  out_sel;
    logic [15:0] skip_cnt;

    typedef struct packed {
        logic [2:0]  chan;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp;
    logic [7:0] mon_xfer;

    int n_checks = 0;
    int n_pass   = 0;

    dmux8_dispatch #(.DATA_W(16), .MAX_WAIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .chan_en   (chan_en),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .skip_cnt  (skip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: any valid&ready at the negedge is a transfer at the next posedge.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_xfer = out_valid & out_ready;
            if (mon_xfer != 8'h00) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL xfer_unexpected: sel=%0d data=%h valid=%b, none expected",
                             out_sel, out_data, out_valid);
                end else begin
                    mon_exp = sb.pop_front();
                    if (out_sel !== mon_exp.chan || out_data !== mon_exp.data ||
                        out_valid !== (8'd1 << mon_exp.chan)) begin
                        $display("FAIL xfer: sel=%0d data=%h valid=%b, required sel=%0d data=%h",
                                 out_sel, out_data, out_valid, mon_exp.chan, mon_exp.data);
                    end else begin
                        n_pass++;
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        chan_en   = 8'hFF;
        out_ready = 8'hFF;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge with in_valid still high.
    task automatic send_word(input logic [15:0] d, input logic [2:0] ch,
                             output int waited, output logic [7:0] ov_acc);
        bit ok;
        waited   = 0;
        ov_acc   = 8'h00;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                sb.push_back('{chan: ch, data: d});
                ov_acc = out_valid;
                ok     = 1'b1;
                break;
            end
            waited++;
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL accept_timeout: word %h not accepted in 20 cycles", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int cycles);
        in_valid = 1'b0;
        repeat (cycles) @(negedge clk);
        n_checks++;
        if (sb.size() !== 0) $display("FAIL drain: %0d words undelivered, required 0", sb.size());
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1)   $display("FAIL rst_in_ready: %b, required 1", in_ready);   else n_pass++;
        n_checks++; if (out_valid !== 8'h00) $display("FAIL rst_out_valid: %h, required 00", out_valid); else n_pass++;
        n_checks++; if (out_sel !== 3'd0)    $display("FAIL rst_out_sel: %0d, required 0", out_sel);    else n_pass++;
        n_checks++; if (out_data !== 16'h0)  $display("FAIL rst_out_data: %h, required 0", out_data);   else n_pass++;
        n_checks++; if (skip_cnt !== 16'h0)  $display("FAIL rst_skip_cnt: %0d, required 0", skip_cnt);  else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        int w; logic [7:0] ov;
        chan_en = 8'hFF; out_ready = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            send_word(16'hA000 + 16'(i), 3'(i % 8), w, ov);
            n_checks++;
            if (w !== 0) $display("FAIL stream_ready: word %0d waited %0d, required 0", i, w);
            else n_pass++;
        end
        drain(4);
        n_checks++; if (out_sel !== 3'd2) $display("FAIL stream_ptr: %0d, required 2", out_sel); else n_pass++;
    endtask

    task automatic test_mask();
        int w; logic [7:0] ov;
        logic [2:0] chs [5] = '{3'd0, 3'd2, 3'd5, 3'd7, 3'd0};
        apply_reset();
        chan_en = 8'b1010_0101;
        for (int i = 0; i < 5; i++) send_word(16'hB000 + 16'(i), chs[i], w, ov);
        drain(4);
        n_checks++; if (skip_cnt !== 16'd0) $display("FAIL mask_skip: %0d, required 0", skip_cnt); else n_pass++;
        n_checks++; if (out_sel !== 3'd2)   $display("FAIL mask_ptr: %0d, required 2", out_sel);   else n_pass++;
    endtask

    task automatic test_stall();
        int w; logic [7:0] ov;
        apply_reset();
        send_word(16'hC000, 3'd0, w, ov);
        out_ready = 8'hFD;
        send_word(16'hC001, 3'd2, w, ov);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 8'h02 || in_ready !== 1'b0)
                $display("FAIL stall_hold: cycle %0d valid=%h ready=%b, required 02/0", i, out_valid, in_ready);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++; if (out_valid !== 8'h04) $display("FAIL stall_retarget: valid=%h, required 04", out_valid); else n_pass++;
        n_checks++; if (skip_cnt !== 16'd1)  $display("FAIL stall_skip: %0d, required 1", skip_cnt);         else n_pass++;
        @(posedge clk);
        #1;
        drain(3);
        out_ready = 8'hFF;
    endtask

    task automatic test_disabled();
        int w; logic [7:0] ov;
        apply_reset();
        chan_en = 8'h00;
        send_word(16'hD00D, 3'd3, w, ov);
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 8'h00 || out_sel !== 3'd0)
                $display("FAIL dis_idle: cycle %0d valid=%h sel=%0d, required 00/0", i, out_valid, out_sel);
            else n_pass++;
        end
        @(posedge clk);
        #1 chan_en = 8'h08;
        @(negedge clk);
        n_checks++; if (out_valid !== 8'h00) $display("FAIL dis_advance: valid=%h, required 00", out_valid); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 8'h08 || out_sel !== 3'd3)
            $display("FAIL dis_deliver: valid=%h sel=%0d, required 08/3", out_valid, out_sel);
        else n_pass++;
        @(posedge clk);
        #1;
        drain(3);
    endtask

    task automatic test_back_to_back();
        int w [4]; logic [7:0] ov [4];
        int req_w [4] = '{0, 1, 0, 0};
        apply_reset();
        chan_en = 8'h10;
        for (int i = 0; i < 4; i++) send_word(16'hE000 + 16'(i), 3'd4, w[i], ov[i]);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (w[i] !== req_w[i]) $display("FAIL b2b_wait: word %0d waited %0d, required %0d", i, w[i], req_w[i]);
            else n_pass++;
        end
        for (int i = 2; i < 4; i++) begin
            n_checks++;
            if (ov[i] !== 8'h10) $display("FAIL b2b_hold: word %0d valid=%h at accept, required 10", i, ov[i]);
            else n_pass++;
        end
        drain(4);
        n_checks++; if (out_sel !== 3'd4) $display("FAIL b2b_ptr: %0d, required 4", out_sel); else n_pass++;
    endtask

    task automatic test_reset_pulse();
        int w; logic [7:0] ov;
        apply_reset();
        out_ready = 8'h00;
        send_word(16'hF00F, 3'd0, w, ov);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++; if (skip_cnt !== 16'd1)  $display("FAIL pulse_pre_skip: %0d, required 1", skip_cnt);  else n_pass++;
        n_checks++; if (out_valid === 8'h00) $display("FAIL pulse_pre_valid: %h, required nonzero", out_valid); else n_pass++;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #2;
        n_checks++; if (out_valid !== 8'h00) $display("FAIL pulse_valid: %h, required 00", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1)   $display("FAIL pulse_ready: %b, required 1", in_ready);   else n_pass++;
        n_checks++; if (skip_cnt !== 16'd0)  $display("FAIL pulse_skip: %0d, required 0", skip_cnt);  else n_pass++;
        n_checks++; if (out_sel !== 3'd0)    $display("FAIL pulse_sel: %0d, required 0", out_sel);    else n_pass++;
        #1 rst_n = 1'b1;
        sb.delete();
        out_ready = 8'hFF;
        drain(8);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        chan_en   = 8'hFF;
        out_ready = 8'hFF;
        test_reset();
        test_stream();
        test_mask();
        test_stall();
        test_disabled();
        test_back_to_back();
        test_reset_pulse();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
